glitch_sweep_sched: RTL

Sequences repeated reset-and-glitch attempts against the target SoC and sweeps glitch delay and glitch length over a configured 2-D grid. Each attempt classifies the 8-bit debug GPIO code and emits a 7-byte log record over a byte-stream handshake to the UART queue. Sweeping halts on a success code. Sits between the button/host start logic and the reset/glitch MOSFET drivers, replacing ad-hoc button-bounce timing.

---
 rtl/glitch_sweep_sched.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/glitch_sweep_sched.sv
// ----------------------------------------------------------------------------
// glitch_sweep_sched : reset/glitch attempt sequencer with a 2-D delay/length
//                      sweep and a 7-byte per-attempt log record stream
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module glitch_sweep_sched #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter logic [15:0] DELAY_MIN      = 16'h0700,
    parameter logic [15:0] DELAY_MAX      = 16'h0727,
    parameter logic [15:0] LEN_MIN        = 16'h0180,
    parameter logic [15:0] LEN_MAX        = 16'h0190,
    parameter logic [23:0] OBSERVE_CYCLES = 24'h0F0000,
    parameter logic [7:0]  SUCCESS_A      = 8'h88,
    parameter logic [7:0]  SUCCESS_B      = 8'h25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  dbg_code,
    output logic        reset_out,
    output logic        glitch_out,
    output logic        busy,
    output logic        hit,
    output logic        sweep_done,
    output logic [15:0] cur_delay,
    output logic [15:0] cur_len,
    output logic [7:0]  log_data,
    output logic        log_valid,
    input  logic        log_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_DELAY   = 3'd2,
        S_GLITCH  = 3'd3,
        S_OBSERVE = 3'd4,
        S_REPORT  = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [23:0] C_RESET_LOAD = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] C_OBS_LOAD   = OBSERVE_CYCLES - 24'd1;
    localparam logic [2:0]  C_LAST_BYTE  = 3'd6;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  result_q, result_d;
    logic        hit_q, hit_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] len_q, len_d;
    logic        reset_out_q, reset_out_d;
    logic        glitch_out_q, glitch_out_d;
    logic        busy_q, busy_d;
    logic        sweep_done_q, sweep_done_d;
    logic        log_valid_q, log_valid_d;
    logic [7:0]  log_data_q, log_data_d;

    logic        accept;
    logic        success;

    assign accept  = log_valid_q & log_ready;
    assign success = (dbg_code == SUCCESS_A) || (dbg_code == SUCCESS_B);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        result_d     = result_q;
        hit_d        = hit_q;
        delay_d      = delay_q;
        len_d        = len_q;
        sweep_done_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RESET;
                        cnt_d   = C_RESET_LOAD;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state_d = S_RESET;
                        cnt_d   = C_RESET_LOAD;
                        hit_d   = 1'b0;
                    end
                end
                S_RESET: begin
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else if (delay_q == 16'd0) begin
                        // zero delay: glitch fires straight after reset release
                        state_d = S_GLITCH;
                        cnt_d   = {8'd0, len_q} - 24'd1;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = {8'd0, delay_q} - 24'd1;
                    end
                end
                S_DELAY: begin
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else begin
                        state_d = S_GLITCH;
                        cnt_d   = {8'd0, len_q} - 24'd1;
                    end
                end
                S_GLITCH: begin
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end else begin
                        state_d = S_OBSERVE;
                        cnt_d   = C_OBS_LOAD;
                    end
                end
                S_OBSERVE: begin
                    if (success || (cnt_q == 24'd0)) begin
                        state_d  = S_REPORT;
                        result_d = dbg_code;
                        idx_d    = 3'd0;
                        hit_d    = hit_q | success;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
                S_REPORT: begin
                    if (accept && (idx_q != C_LAST_BYTE)) begin
                        idx_d = idx_q + 3'd1;
                    end else if (accept) begin
                        idx_d = 3'd0;
                        cnt_d = C_RESET_LOAD;
                        if (hit_q) begin
                            state_d = S_HALT;
                        end else if (delay_q < DELAY_MAX) begin
                            delay_d = delay_q + 16'd1;
                            state_d = S_RESET;
                        end else if (len_q < LEN_MAX) begin
                            delay_d = DELAY_MIN;
                            len_d   = len_q + 16'd1;
                            state_d = S_RESET;
                        end else begin
                            delay_d      = DELAY_MIN;
                            len_d        = LEN_MIN;
                            sweep_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Drive outputs from the next state so they come straight off flops
        reset_out_d  = (state_d == S_RESET);
        glitch_out_d = (state_d == S_GLITCH);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
        log_valid_d  = (state_d == S_REPORT);
    end

    always_comb begin
        log_data_d = 8'h00;
        if (state_d == S_REPORT) begin
            case (idx_d)
                3'd0:    log_data_d = 8'h55;
                3'd1:    log_data_d = 8'hAA;
                3'd2:    log_data_d = delay_q[15:8];
                3'd3:    log_data_d = delay_q[7:0];
                3'd4:    log_data_d = len_q[15:8];
                3'd5:    log_data_d = len_q[7:0];
                3'd6:    log_data_d = result_d;
                default: log_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= 24'd0;
            idx_q        <= 3'd0;
            result_q     <= 8'h00;
            hit_q        <= 1'b0;
            delay_q      <= DELAY_MIN;
            len_q        <= LEN_MIN;
            reset_out_q  <= 1'b0;
            glitch_out_q <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            log_valid_q  <= 1'b0;
            log_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            result_q     <= result_d;
            hit_q        <= hit_d;
            delay_q      <= delay_d;
            len_q        <= len_d;
            reset_out_q  <= reset_out_d;
            glitch_out_q <= glitch_out_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            log_valid_q  <= log_valid_d;
            log_data_q   <= log_data_d;
        end
    end

    assign reset_out  = reset_out_q;
    assign glitch_out = glitch_out_q;
    assign busy       = busy_q;
    assign hit        = hit_q;
    assign sweep_done = sweep_done_q;
    assign cur_delay  = delay_q;
    assign cur_len    = len_q;
    assign log_data   = log_data_q;
    assign log_valid  = log_valid_q;

endmodule

`default_nettype wire
